ahb_mem_arbiter: RTL and testbench
==================================

# ahb_mem_arbiter

Two-master AHB-lite arbiter with an exclusive-access monitor, placed between the two hart ports and the single SDRAM/cache memory slave (ahb_sync_sram). It buffers the address phase of a losing master, grants round-robin, and issues only NONSEQ single transfers downstream. LR/SC atomics are resolved here: failed store-conditionals complete locally without touching SDRAM.

## Interface
Parameters:
- W_ADDR, 32, address width
- W_DATA, 32, data width
- RESV_LSB, 2, low address bits ignored in reservation compare (word granule)

Ports (sN_ = one identical port per master, N = 0, 1):
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sN_hready  in  1  upstream global hready of master N
- sN_hready_resp  out  1  data-phase ready to master N
- sN_hresp  out  1  error response; tied 0
- sN_haddr  in  W_ADDR  address
- sN_hwrite  in  1  write
- sN_htrans  in  2  transfer type; only bit 1 is used
- sN_hsize  in  3  size
- sN_hwdata  in  W_DATA  write data (data phase)
- sN_hexcl  in  1  exclusive access
- sN_hrdata  out  W_DATA  read data
- sN_hexokay  out  1  exclusive success
- m_hready  out  1  to slave ahbls_hready
- m_hready_resp  in  1  from slave ahbls_hready_resp
- m_haddr  out  W_ADDR  address; m_hwrite, m_hsize, m_hexcl  out  same widths
- m_htrans  out  2  2'b10 or 2'b00 only
- m_hmaster  out  8  granted master index, zero-extended
- m_hwdata  out  W_DATA  write data, muxed by data-phase owner
- m_hrdata  in  W_DATA  read data

## Operation
- Request N: live (sN_htrans[1] & sN_hready, no pending) or pending buffer N valid.
- Arbitration runs only when the downstream address phase can be accepted (m_hready high). Round-robin: the master not last granted wins. After reset, last = 1, so master 0 wins first.
- Winner is driven onto m_* combinationally from the live inputs or the buffer. A live loser is captured into its buffer (addr, write, size, excl). At most one buffered request per master.
- sN_hready_resp: m_hready_resp while N owns the downstream data phase; 1 during a local-completion cycle for N; 0 while buffer N is valid and not completed; 1 otherwise.
- m_hready = m_hready_resp when a downstream data phase is active, else 1.
- Data-phase tracking: dph_valid, dph_owner, dph_local, dph_excl_ok registers, updated when m_hready is high.
- Exclusive monitor, one reservation per master (valid + addr[W_ADDR-1:RESV_LSB]):
  - An issued exclusive read sets reservation N, and its hexokay = 1.
  - An exclusive write from N succeeds iff reservation N is valid and the address matches. On success it is issued downstream with hexokay = 1. On failure it is not issued (m_htrans 00), completes locally in one cycle with hexokay = 0, and hrdata = 0.
  - Any exclusive write by N clears reservation N.
  - Any issued write (normal or successful exclusive) clears the other master's reservation on address match.
- Non-exclusive transfers report hexokay = 0. sN_hrdata = m_hrdata for both ports. SEQ is treated as NONSEQ; BUSY is treated as IDLE.

## Timing
- Reset values: sN_hready_resp = 1, sN_hexokay = 0, m_htrans = 00, m_hmaster = 0, buffers empty, reservations invalid, last = 1, dph_valid = 0.
- Uncontended request: issued in the same cycle as the upstream address phase. Zero added latency.
- Loser: buffered at the clock edge and issued at the next arbitration slot; 1 extra cycle minimum.
- Simultaneous exclusive writes to the same reserved word: the winner succeeds, and its issue clears the loser's reservation in the same edge, so the loser fails.
- A reservation set and a clearing write at the same edge: the clear wins.
- Reset mid-transfer abandons all state; the slave must be reset together with the arbiter.

## Structure
- Package ahb_arb_pkg: HTRANS_IDLE/NONSEQ constants, request record (addr, write, size, excl), master-index width.
- Sub-module ahb_excl_monitor: the two reservations, the match/clear logic, and the success decision.

## Test plan
- M0 reads 0x100 alone, slave ready -> m_htrans 10 in the same cycle, m_hmaster 0, s0_hready_resp follows m_hready_resp.
- Both request at cycle 0 after reset (M0 read 0x10, M1 write 0x20) -> M0 issued at cycle 0, M1 buffered and issued at the first cycle m_hready = 1, s1_hready_resp = 0 until its data phase ends; m_hwdata = s1_hwdata.
- M0 LR 0x200, then M0 SC 0x200 -> write issued, s0_hexokay = 1; a second SC 0x200 -> no downstream access, hexokay = 0, 1-cycle completion.
- M0 LR 0x300, M1 normal write 0x300, M0 SC 0x300 -> SC fails, hexokay = 0.
- M0 LR 0x400, M1 LR 0x400, both SC same cycle -> winner (M0 per round-robin) hexokay = 1, M1 hexokay = 0, one write to SDRAM.
- Assert rst during a buffered M1 write -> all outputs at reset values; nothing issued after release.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared constants and request record for the two-master AHB-lite memory arbiter.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam int unsigned MST_W      = 1;
    localparam int unsigned REQ_ADDR_W = 32;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic                  excl;
    } req_t;

endpackage

// File: rtl/ahb_excl_monitor.sv
// Per-master LR/SC reservations; decides store-conditional success for the granted request.
module ahb_excl_monitor
    import ahb_arb_pkg::*;
#(
    parameter int unsigned W_ADDR   = 32,
    parameter int unsigned RESV_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gnt_valid,
    input  logic [MST_W-1:0]  gnt_mst,
    input  logic [W_ADDR-1:0] gnt_addr,
    input  logic              gnt_write,
    input  logic              gnt_excl,
    output logic              excl_ok_c
);

    localparam int unsigned TAG_W = W_ADDR - RESV_LSB;

    logic [1:0]       resv_valid_q, resv_valid_d;
    logic [TAG_W-1:0] resv_tag_q [2];
    logic [TAG_W-1:0] resv_tag_d [2];
    logic [TAG_W-1:0] tag_c;
    logic [1:0]       match_c;
    logic             wr_issue_c;
    logic             own_c;
    logic             unused_c;

    assign unused_c = &{1'b0, gnt_addr[RESV_LSB-1:0]};

    always_comb begin
        tag_c = gnt_addr[W_ADDR-1:RESV_LSB];
        for (int i = 0; i < 2; i++) begin
            match_c[i] = resv_valid_q[i] & (resv_tag_q[i] == tag_c);
        end
        excl_ok_c  = match_c[gnt_mst];
        wr_issue_c = gnt_valid & gnt_write & (~gnt_excl | excl_ok_c);
    end

    // Clears are applied after the set so a clearing write always wins.
    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_tag_d   = resv_tag_q;
        own_c        = 1'b0;
        for (int i = 0; i < 2; i++) begin
            own_c = (gnt_mst == MST_W'(i));
            if (gnt_valid && own_c && gnt_excl && !gnt_write) begin
                resv_valid_d[i] = 1'b1;
                resv_tag_d[i]   = tag_c;
            end
            if (gnt_valid && own_c && gnt_excl && gnt_write) begin
                resv_valid_d[i] = 1'b0;
            end
            if (wr_issue_c && !own_c && match_c[i]) begin
                resv_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_valid_q  <= '0;
            resv_tag_q[0] <= '0;
            resv_tag_q[1] <= '0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_tag_q   <= resv_tag_d;
        end
    end

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Round-robin two-master AHB-lite arbiter in front of a single memory slave, with LR/SC resolution.
module ahb_mem_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned W_ADDR   = 32,
    parameter int unsigned W_DATA   = 32,
    parameter int unsigned RESV_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s0_hready,
    output logic              s0_hready_resp,
    output logic              s0_hresp,
    input  logic [W_ADDR-1:0] s0_haddr,
    input  logic              s0_hwrite,
    input  logic [1:0]        s0_htrans,
    input  logic [2:0]        s0_hsize,
    input  logic [W_DATA-1:0] s0_hwdata,
    input  logic              s0_hexcl,
    output logic [W_DATA-1:0] s0_hrdata,
    output logic              s0_hexokay,

    input  logic              s1_hready,
    output logic              s1_hready_resp,
    output logic              s1_hresp,
    input  logic [W_ADDR-1:0] s1_haddr,
    input  logic              s1_hwrite,
    input  logic [1:0]        s1_htrans,
    input  logic [2:0]        s1_hsize,
    input  logic [W_DATA-1:0] s1_hwdata,
    input  logic              s1_hexcl,
    output logic [W_DATA-1:0] s1_hrdata,
    output logic              s1_hexokay,

    output logic              m_hready,
    input  logic              m_hready_resp,
    output logic [W_ADDR-1:0] m_haddr,
    output logic              m_hwrite,
    output logic [1:0]        m_htrans,
    output logic [2:0]        m_hsize,
    output logic              m_hexcl,
    output logic [7:0]        m_hmaster,
    output logic [W_DATA-1:0] m_hwdata,
    input  logic [W_DATA-1:0] m_hrdata
);

    logic [1:0]       pend_valid_q, pend_valid_d;
    req_t             pend_q [2];
    req_t             pend_d [2];
    logic [MST_W-1:0] last_q, last_d;
    logic             dph_valid_q, dph_valid_d;
    logic [MST_W-1:0] dph_owner_q, dph_owner_d;
    logic             dph_local_q, dph_local_d;
    logic             dph_excl_ok_q, dph_excl_ok_d;

    req_t             live_req_c [2];
    req_t             cur_c [2];
    logic [1:0]       live_c, req_c, rdy_c;
    logic [MST_W-1:0] win_c;
    req_t             gnt_req_c;
    logic             gnt_valid_c, excl_ok_c, excl_fail_c, issue_c;
    logic             m_hready_c;
    logic             unused_c;

    assign unused_c = &{1'b0, s0_htrans[0], s1_htrans[0]};

    assign m_hready_c = (dph_valid_q && !dph_local_q) ? m_hready_resp : 1'b1;

    // Request sources and round-robin winner selection.
    always_comb begin
        live_req_c[0].addr  = REQ_ADDR_W'(s0_haddr);
        live_req_c[0].write = s0_hwrite;
        live_req_c[0].size  = s0_hsize;
        live_req_c[0].excl  = s0_hexcl;
        live_req_c[1].addr  = REQ_ADDR_W'(s1_haddr);
        live_req_c[1].write = s1_hwrite;
        live_req_c[1].size  = s1_hsize;
        live_req_c[1].excl  = s1_hexcl;
        live_c[0] = s0_htrans[1] & s0_hready & ~pend_valid_q[0] & ~rst;
        live_c[1] = s1_htrans[1] & s1_hready & ~pend_valid_q[1] & ~rst;
        for (int i = 0; i < 2; i++) begin
            req_c[i] = live_c[i] | pend_valid_q[i];
            cur_c[i] = pend_valid_q[i] ? pend_q[i] : live_req_c[i];
        end
        win_c = '0;
        if (req_c[0] && req_c[1]) begin
            win_c = ~last_q;
        end else if (req_c[1]) begin
            win_c = MST_W'(1);
        end
        gnt_valid_c = m_hready_c & (|req_c);
        gnt_req_c   = cur_c[win_c];
    end

    ahb_excl_monitor #(
        .W_ADDR   (W_ADDR),
        .RESV_LSB (RESV_LSB)
    ) u_excl_monitor (
        .clk       (clk),
        .rst       (rst),
        .gnt_valid (gnt_valid_c),
        .gnt_mst   (win_c),
        .gnt_addr  (W_ADDR'(gnt_req_c.addr)),
        .gnt_write (gnt_req_c.write),
        .gnt_excl  (gnt_req_c.excl),
        .excl_ok_c (excl_ok_c)
    );

    // A failed store-conditional is granted but completes locally instead of going downstream.
    always_comb begin
        excl_fail_c   = gnt_req_c.excl & gnt_req_c.write & ~excl_ok_c;
        issue_c       = gnt_valid_c & ~excl_fail_c;
        pend_valid_d  = pend_valid_q;
        pend_d        = pend_q;
        last_d        = last_q;
        dph_valid_d   = dph_valid_q;
        dph_owner_d   = dph_owner_q;
        dph_local_d   = dph_local_q;
        dph_excl_ok_d = dph_excl_ok_q;
        for (int i = 0; i < 2; i++) begin
            if (gnt_valid_c && win_c == MST_W'(i)) begin
                pend_valid_d[i] = 1'b0;
            end else if (live_c[i]) begin
                pend_valid_d[i] = 1'b1;
                pend_d[i]       = live_req_c[i];
            end
        end
        if (gnt_valid_c) begin
            last_d = win_c;
        end
        if (m_hready_c) begin
            dph_valid_d   = gnt_valid_c;
            dph_owner_d   = win_c;
            dph_local_d   = gnt_valid_c & excl_fail_c;
            dph_excl_ok_d = gnt_valid_c & gnt_req_c.excl & (~gnt_req_c.write | excl_ok_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q  <= '0;
            pend_q[0]     <= '0;
            pend_q[1]     <= '0;
            last_q        <= MST_W'(1);
            dph_valid_q   <= 1'b0;
            dph_owner_q   <= '0;
            dph_local_q   <= 1'b0;
            dph_excl_ok_q <= 1'b0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_q        <= pend_d;
            last_q        <= last_d;
            dph_valid_q   <= dph_valid_d;
            dph_owner_q   <= dph_owner_d;
            dph_local_q   <= dph_local_d;
            dph_excl_ok_q <= dph_excl_ok_d;
        end
    end

    // Upstream ready: data-phase owner follows the slave, a buffered master waits.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (dph_valid_q && dph_owner_q == MST_W'(i)) begin
                rdy_c[i] = dph_local_q ? 1'b1 : m_hready_resp;
            end else if (pend_valid_q[i]) begin
                rdy_c[i] = 1'b0;
            end else begin
                rdy_c[i] = 1'b1;
            end
        end
    end

    assign s0_hready_resp = rdy_c[0];
    assign s1_hready_resp = rdy_c[1];
    assign s0_hresp       = 1'b0;
    assign s1_hresp       = 1'b0;
    assign s0_hexokay     = dph_valid_q & dph_excl_ok_q & (dph_owner_q == MST_W'(0));
    assign s1_hexokay     = dph_valid_q & dph_excl_ok_q & (dph_owner_q == MST_W'(1));
    assign s0_hrdata      = (dph_valid_q && dph_local_q && dph_owner_q == MST_W'(0)) ? '0 : m_hrdata;
    assign s1_hrdata      = (dph_valid_q && dph_local_q && dph_owner_q == MST_W'(1)) ? '0 : m_hrdata;

    assign m_hready  = m_hready_c;
    assign m_htrans  = issue_c ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign m_haddr   = issue_c ? W_ADDR'(gnt_req_c.addr) : '0;
    assign m_hwrite  = issue_c & gnt_req_c.write;
    assign m_hsize   = issue_c ? gnt_req_c.size : 3'b000;
    assign m_hexcl   = issue_c & gnt_req_c.excl;
    assign m_hmaster = issue_c ? 8'(win_c) : 8'h00;
    assign m_hwdata  = (dph_owner_q == MST_W'(1)) ? s1_hwdata : s0_hwdata;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter: contention, LR/SC outcomes and reset mid-transfer.
module tb_ahb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_hready, s0_hready_resp, s0_hresp, s0_hwrite, s0_hexcl, s0_hexokay;
    logic [31:0] s0_haddr, s0_hwdata, s0_hrdata;
    logic [1:0]  s0_htrans;
    logic [2:0]  s0_hsize;
    logic        s1_hready, s1_hready_resp, s1_hresp, s1_hwrite, s1_hexcl, s1_hexokay;
    logic [31:0] s1_haddr, s1_hwdata, s1_hrdata;
    logic [1:0]  s1_htrans;
    logic [2:0]  s1_hsize;
    logic        m_hready, m_hready_resp, m_hwrite, m_hexcl;
    logic [31:0] m_haddr, m_hwdata, m_hrdata;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hsize;
    logic [7:0]  m_hmaster;

    int tests_run    = 0;
    int tests_failed = 0;
    int issue_count  = 0;
    int wr_count     = 0;
    int base;

    always #5 clk = ~clk;

    assign s0_hready = s0_hready_resp;
    assign s1_hready = s1_hready_resp;

    ahb_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_hready(s0_hready), .s0_hready_resp(s0_hready_resp), .s0_hresp(s0_hresp),
        .s0_haddr(s0_haddr), .s0_hwrite(s0_hwrite), .s0_htrans(s0_htrans), .s0_hsize(s0_hsize),
        .s0_hwdata(s0_hwdata), .s0_hexcl(s0_hexcl), .s0_hrdata(s0_hrdata), .s0_hexokay(s0_hexokay),
        .s1_hready(s1_hready), .s1_hready_resp(s1_hready_resp), .s1_hresp(s1_hresp),
        .s1_haddr(s1_haddr), .s1_hwrite(s1_hwrite), .s1_htrans(s1_htrans), .s1_hsize(s1_hsize),
        .s1_hwdata(s1_hwdata), .s1_hexcl(s1_hexcl), .s1_hrdata(s1_hrdata), .s1_hexokay(s1_hexokay),
        .m_hready(m_hready), .m_hready_resp(m_hready_resp), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
        .m_htrans(m_htrans), .m_hsize(m_hsize), .m_hexcl(m_hexcl), .m_hmaster(m_hmaster),
        .m_hwdata(m_hwdata), .m_hrdata(m_hrdata)
    );

    // Slave-side observer: counts accepted downstream address phases.
    always @(posedge clk) begin
        if (!rst && m_hready && m_htrans[1]) begin
            issue_count++;
            if (m_hwrite) wr_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0(input logic act, input logic [31:0] a, input logic wr, input logic ex);
        s0_htrans = act ? 2'b10 : 2'b00;
        s0_haddr  = a;
        s0_hwrite = wr;
        s0_hexcl  = ex;
        s0_hsize  = 3'b010;
    endtask

    task automatic m1(input logic act, input logic [31:0] a, input logic wr, input logic ex);
        s1_htrans = act ? 2'b10 : 2'b00;
        s1_haddr  = a;
        s1_hwrite = wr;
        s1_hexcl  = ex;
        s1_hsize  = 3'b010;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        m1(1'b0, 32'h0, 1'b0, 1'b0);
        m_hready_resp = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        m1(1'b0, 32'h0, 1'b0, 1'b0);
        s0_hwdata = 32'h0; s1_hwdata = 32'h0;
        m_hready_resp = 1'b1; m_hrdata = 32'hCAFE_0000;
        @(negedge clk);
        tests_run++; if (s0_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL rst_s0_rdy: got %b want 1", s0_hready_resp); end
        tests_run++; if (s1_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL rst_s1_rdy: got %b want 1", s1_hready_resp); end
        tests_run++; if (s0_hexokay !== 1'b0) begin tests_failed++; $display("FAIL rst_s0_exok: got %b want 0", s0_hexokay); end
        tests_run++; if (m_htrans !== 2'b00) begin tests_failed++; $display("FAIL rst_htrans: got %b want 00", m_htrans); end
        tests_run++; if (m_hmaster !== 8'h00) begin tests_failed++; $display("FAIL rst_hmaster: got %h want 00", m_hmaster); end
        tests_run++; if (m_hready !== 1'b1) begin tests_failed++; $display("FAIL rst_mready: got %b want 1", m_hready); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        m_hrdata = 32'hCAFE_0100;
        m0(1'b1, 32'h100, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++; if (m_htrans !== 2'b10) begin tests_failed++; $display("FAIL rd_htrans: got %b want 10", m_htrans); end
        tests_run++; if (m_haddr !== 32'h100) begin tests_failed++; $display("FAIL rd_haddr: got %h want 100", m_haddr); end
        tests_run++; if (m_hmaster !== 8'h00) begin tests_failed++; $display("FAIL rd_hmaster: got %h want 00", m_hmaster); end
        tick();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        m_hready_resp = 1'b0;
        @(negedge clk);
        tests_run++; if (s0_hready_resp !== 1'b0) begin tests_failed++; $display("FAIL rd_s0_stall: got %b want 0", s0_hready_resp); end
        tests_run++; if (m_hready !== 1'b0) begin tests_failed++; $display("FAIL rd_mready_stall: got %b want 0", m_hready); end
        tick();
        m_hready_resp = 1'b1;
        @(negedge clk);
        tests_run++; if (s0_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL rd_s0_done: got %b want 1", s0_hready_resp); end
        tests_run++; if (s0_hrdata !== 32'hCAFE_0100) begin tests_failed++; $display("FAIL rd_hrdata: got %h want cafe0100", s0_hrdata); end
        tests_run++; if (s0_hexokay !== 1'b0) begin tests_failed++; $display("FAIL rd_exok: got %b want 0", s0_hexokay); end
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        base = wr_count;
        m0(1'b1, 32'h10, 1'b0, 1'b0);
        m1(1'b1, 32'h20, 1'b1, 1'b0);
        @(negedge clk);
        tests_run++; if (m_haddr !== 32'h10) begin tests_failed++; $display("FAIL ct_c0_haddr: got %h want 10", m_haddr); end
        tests_run++; if (m_hmaster !== 8'h00) begin tests_failed++; $display("FAIL ct_c0_hmaster: got %h want 00", m_hmaster); end
        tests_run++; if (m_hwrite !== 1'b0) begin tests_failed++; $display("FAIL ct_c0_hwrite: got %b want 0", m_hwrite); end
        tick();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        m1(1'b0, 32'h0, 1'b0, 1'b0);
        s0_hwdata = 32'h1111_1111; s1_hwdata = 32'hA5A5_0020;
        m_hready_resp = 1'b0;
        @(negedge clk);
        tests_run++; if (m_htrans !== 2'b00) begin tests_failed++; $display("FAIL ct_c1_htrans: got %b want 00", m_htrans); end
        tests_run++; if (s1_hready_resp !== 1'b0) begin tests_failed++; $display("FAIL ct_c1_s1_rdy: got %b want 0", s1_hready_resp); end
        tick();
        m_hready_resp = 1'b1;
        @(negedge clk);
        tests_run++; if (m_htrans !== 2'b10) begin tests_failed++; $display("FAIL ct_c2_htrans: got %b want 10", m_htrans); end
        tests_run++; if (m_haddr !== 32'h20) begin tests_failed++; $display("FAIL ct_c2_haddr: got %h want 20", m_haddr); end
        tests_run++; if (m_hmaster !== 8'h01) begin tests_failed++; $display("FAIL ct_c2_hmaster: got %h want 01", m_hmaster); end
        tests_run++; if (s1_hready_resp !== 1'b0) begin tests_failed++; $display("FAIL ct_c2_s1_rdy: got %b want 0", s1_hready_resp); end
        tests_run++; if (s0_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL ct_c2_s0_rdy: got %b want 1", s0_hready_resp); end
        tick();
        @(negedge clk);
        tests_run++; if (m_hwdata !== 32'hA5A5_0020) begin tests_failed++; $display("FAIL ct_c3_hwdata: got %h want a5a50020", m_hwdata); end
        tests_run++; if (s1_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL ct_c3_s1_rdy: got %b want 1", s1_hready_resp); end
        tests_run++; if (wr_count - base !== 1) begin tests_failed++; $display("FAIL ct_writes: got %0d want 1", wr_count - base); end
        tick();
    endtask

    task automatic test_lr_sc();
        do_reset();
        base = wr_count;
        m_hrdata = 32'hDEAD_BEEF;
        m0(1'b1, 32'h200, 1'b0, 1'b1);
        @(negedge clk);
        tests_run++; if (m_hexcl !== 1'b1) begin tests_failed++; $display("FAIL lr_hexcl: got %b want 1", m_hexcl); end
        tick();
        m0(1'b1, 32'h200, 1'b1, 1'b1);
        @(negedge clk);
        tests_run++; if (s0_hexokay !== 1'b1) begin tests_failed++; $display("FAIL lr_exok: got %b want 1", s0_hexokay); end
        tests_run++; if (m_htrans !== 2'b10) begin tests_failed++; $display("FAIL sc1_htrans: got %b want 10", m_htrans); end
        tick();
        @(negedge clk);
        tests_run++; if (s0_hexokay !== 1'b1) begin tests_failed++; $display("FAIL sc1_exok: got %b want 1", s0_hexokay); end
        tests_run++; if (m_htrans !== 2'b00) begin tests_failed++; $display("FAIL sc2_htrans: got %b want 00", m_htrans); end
        tick();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++; if (s0_hexokay !== 1'b0) begin tests_failed++; $display("FAIL sc2_exok: got %b want 0", s0_hexokay); end
        tests_run++; if (s0_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL sc2_rdy: got %b want 1", s0_hready_resp); end
        tests_run++; if (s0_hrdata !== 32'h0) begin tests_failed++; $display("FAIL sc2_hrdata: got %h want 0", s0_hrdata); end
        tests_run++; if (wr_count - base !== 1) begin tests_failed++; $display("FAIL lrsc_writes: got %0d want 1", wr_count - base); end
        tick();
    endtask

    task automatic test_sc_lost();
        do_reset();
        m0(1'b1, 32'h300, 1'b0, 1'b1);
        tick();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        m1(1'b1, 32'h300, 1'b1, 1'b0);
        @(negedge clk);
        tests_run++; if (m_hmaster !== 8'h01) begin tests_failed++; $display("FAIL lost_wr_hmaster: got %h want 01", m_hmaster); end
        tick();
        m1(1'b0, 32'h0, 1'b0, 1'b0);
        m0(1'b1, 32'h300, 1'b1, 1'b1);
        @(negedge clk);
        tests_run++; if (m_htrans !== 2'b00) begin tests_failed++; $display("FAIL lost_sc_htrans: got %b want 00", m_htrans); end
        tests_run++; if (s1_hexokay !== 1'b0) begin tests_failed++; $display("FAIL lost_wr_exok: got %b want 0", s1_hexokay); end
        tick();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++; if (s0_hexokay !== 1'b0) begin tests_failed++; $display("FAIL lost_sc_exok: got %b want 0", s0_hexokay); end
        tests_run++; if (s0_hrdata !== 32'h0) begin tests_failed++; $display("FAIL lost_sc_hrdata: got %h want 0", s0_hrdata); end
        tick();
    endtask

    task automatic test_simul_sc();
        do_reset();
        m0(1'b1, 32'h400, 1'b0, 1'b1);
        tick();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        m1(1'b1, 32'h400, 1'b0, 1'b1);
        @(negedge clk);
        tests_run++; if (s0_hexokay !== 1'b1) begin tests_failed++; $display("FAIL sim_lr0_exok: got %b want 1", s0_hexokay); end
        tick();
        base = wr_count;
        m0(1'b1, 32'h400, 1'b1, 1'b1);
        m1(1'b1, 32'h400, 1'b1, 1'b1);
        @(negedge clk);
        tests_run++; if (s1_hexokay !== 1'b1) begin tests_failed++; $display("FAIL sim_lr1_exok: got %b want 1", s1_hexokay); end
        tests_run++; if (m_hmaster !== 8'h00) begin tests_failed++; $display("FAIL sim_hmaster: got %h want 00", m_hmaster); end
        tests_run++; if (m_htrans !== 2'b10) begin tests_failed++; $display("FAIL sim_htrans: got %b want 10", m_htrans); end
        tick();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        m1(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++; if (s0_hexokay !== 1'b1) begin tests_failed++; $display("FAIL sim_sc0_exok: got %b want 1", s0_hexokay); end
        tests_run++; if (s1_hready_resp !== 1'b0) begin tests_failed++; $display("FAIL sim_s1_wait: got %b want 0", s1_hready_resp); end
        tests_run++; if (m_htrans !== 2'b00) begin tests_failed++; $display("FAIL sim_sc1_htrans: got %b want 00", m_htrans); end
        tick();
        @(negedge clk);
        tests_run++; if (s1_hexokay !== 1'b0) begin tests_failed++; $display("FAIL sim_sc1_exok: got %b want 0", s1_hexokay); end
        tests_run++; if (s1_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL sim_s1_done: got %b want 1", s1_hready_resp); end
        tests_run++; if (wr_count - base !== 1) begin tests_failed++; $display("FAIL sim_writes: got %0d want 1", wr_count - base); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0(1'b1, 32'h10, 1'b0, 1'b0);
        m1(1'b1, 32'h20, 1'b1, 1'b0);
        tick();
        m0(1'b0, 32'h0, 1'b0, 1'b0);
        m1(1'b0, 32'h0, 1'b0, 1'b0);
        m_hready_resp = 1'b0;
        @(negedge clk);
        tests_run++; if (s1_hready_resp !== 1'b0) begin tests_failed++; $display("FAIL mid_s1_buf: got %b want 0", s1_hready_resp); end
        #1 rst = 1'b1;
        #1;
        tests_run++; if (s0_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL mid_s0_rdy: got %b want 1", s0_hready_resp); end
        tests_run++; if (s1_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL mid_s1_rdy: got %b want 1", s1_hready_resp); end
        tests_run++; if (m_hready !== 1'b1) begin tests_failed++; $display("FAIL mid_mready: got %b want 1", m_hready); end
        tests_run++; if (m_htrans !== 2'b00) begin tests_failed++; $display("FAIL mid_htrans: got %b want 00", m_htrans); end
        tests_run++; if (m_hmaster !== 8'h00) begin tests_failed++; $display("FAIL mid_hmaster: got %h want 00", m_hmaster); end
        base = issue_count;
        tick();
        rst = 1'b0;
        m_hready_resp = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        tests_run++; if (issue_count - base !== 0) begin tests_failed++; $display("FAIL mid_no_issue: got %0d want 0", issue_count - base); end
        tests_run++; if (s1_hready_resp !== 1'b1) begin tests_failed++; $display("FAIL mid_s1_after: got %b want 1", s1_hready_resp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_lr_sc();
        test_sc_lost();
        test_simul_sc();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
